// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : game_pkg                                               |
// | Description : Shared types and constants for the game screen path:   |
// |               screen identifiers, fetch FSM states, image geometry.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package game_pkg;

  // Full-screen image selector; the encoding doubles as the ROM select.
  typedef enum logic [1:0] {
    START   = 2'd0,
    KEEPER  = 2'd1,
    SHOOTER = 2'd2
  } screen_t;

  // Fetch FSM: hold the picture dark until a clean frame start is seen.
  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } fetch_state_t;

  localparam int          HOR_PIXELS = 1024;
  localparam int          VER_PIXELS = 768;
  localparam logic [11:0] BG_COLOR   = 12'h000;

  // The reserved request code falls back to the start screen.
  function automatic screen_t decode_screen(input logic [1:0] req);
    screen_t s;
    case (req)
      2'd1:    s = KEEPER;
      2'd2:    s = SHOOTER;
      default: s = START;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vga_delay                                              |
// | Description : Fixed-depth delay line for the VGA timing bundle       |
// |               (counts, syncs, blanks) so that draw blocks can keep   |
// |               timing aligned with their pixel pipeline.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vga_delay #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hblnk_i,
  input  logic        vblnk_i,
  output logic [10:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        hblnk_o,
  output logic        vblnk_o
);

  localparam int BUNDLE_W = 26;

  logic [BUNDLE_W-1:0] stage_q [DEPTH];
  logic [BUNDLE_W-1:0] bundle_d;

  assign bundle_d = {hcount_i, vcount_i, hsync_i, vsync_i, hblnk_i, vblnk_i};

  // Shift the timing bundle one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= bundle_d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o} = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/screen_rom_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : screen_rom_fetch                                       |
// | Description : Turns VGA timing into full-screen ROM addresses, picks |
// |               the ROM for the active screen, captures the returned   |
// |               pixel and re-aligns timing to it (3-cycle latency).    |
// |               Screen changes are applied only at start of frame.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module screen_rom_fetch #(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DATA_WIDTH = 12,
  parameter int                    IMG_W      = game_pkg::HOR_PIXELS,
  parameter int                    IMG_H      = game_pkg::VER_PIXELS,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR   = DATA_WIDTH'(game_pkg::BG_COLOR),
  parameter int                    ROM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            screen_req,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [1:0]            rom_sel,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [DATA_WIDTH-1:0] rgb_out,
  output logic [1:0]            screen_active
);

  import game_pkg::*;

  // Address stage + ROM read + output stage.
  localparam int PIPE_DEPTH = ROM_LAT + 2;

  fetch_state_t state_q, state_d;
  screen_t      screen_active_q, screen_active_d;
  screen_t      req_screen;
  logic         sof;

  // Stage 1: address, select and per-pixel qualifiers.
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  screen_t               rom_sel_q, rom_sel_d;
  logic                  in_img1_q, in_img_d;
  logic                  blank1_q, blank_d;
  logic                  show1_q, show_d;
  // Stage 2: qualifiers travelling alongside the ROM read.
  logic                  in_img2_q, blank2_q, show2_q;
  // Stage 3: final pixel.
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;

  assign sof        = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign req_screen = decode_screen(screen_req);

  // Modular arithmetic at ADDR_WIDTH equals full-width product then truncation.
  assign rom_addr_d = ADDR_WIDTH'(vcount_in) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(hcount_in);
  // The SOF pixel already fetches from the newly requested screen.
  assign rom_sel_d  = sof ? req_screen : screen_active_q;
  assign blank_d    = hblnk_in | vblnk_in;
  assign in_img_d   = (32'(hcount_in) < 32'(IMG_W)) && (32'(vcount_in) < 32'(IMG_H)) && !blank_d;
  // A pixel is shown only if it belongs to a frame whose start was seen,
  // so no partial frame leaks out after reset.
  assign show_d     = (state_q == RUN) || sof;

  // FSM state and active-screen register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= WAIT_SOF;
      screen_active_q <= START;
    end else begin
      state_q         <= state_d;
      screen_active_q <= screen_active_d;
    end
  end

  // Next state: leave WAIT_SOF on frame start; latch the screen at every SOF.
  always_comb begin
    state_d         = state_q;
    screen_active_d = screen_active_q;
    case (state_q)
      WAIT_SOF: if (sof) state_d = RUN;
      RUN:      state_d = RUN;
      default:  state_d = WAIT_SOF;
    endcase
    if (sof) screen_active_d = req_screen;
  end

  // Pixel pipeline registers for stages 1 to 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      rom_sel_q  <= START;
      in_img1_q  <= 1'b0;
      blank1_q   <= 1'b0;
      show1_q    <= 1'b0;
      in_img2_q  <= 1'b0;
      blank2_q   <= 1'b0;
      show2_q    <= 1'b0;
      rgb_q      <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      rom_sel_q  <= rom_sel_d;
      in_img1_q  <= in_img_d;
      blank1_q   <= blank_d;
      show1_q    <= show_d;
      in_img2_q  <= in_img1_q;
      blank2_q   <= blank1_q;
      show2_q    <= show1_q;
      rgb_q      <= rgb_d;
    end
  end

  // Output colour: dark when hidden or blanked, background outside the image.
  always_comb begin
    rgb_d = '0;
    if (show2_q && !blank2_q) begin
      rgb_d = in_img2_q ? rom_data : BG_COLOR;
    end
  end

  vga_delay #(
    .DEPTH (PIPE_DEPTH)
  ) u_vga_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .hcount_i (hcount_in),
    .vcount_i (vcount_in),
    .hsync_i  (hsync_in),
    .vsync_i  (vsync_in),
    .hblnk_i  (hblnk_in),
    .vblnk_i  (vblnk_in),
    .hcount_o (hcount_out),
    .vcount_o (vcount_out),
    .hsync_o  (hsync_out),
    .vsync_o  (vsync_out),
    .hblnk_o  (hblnk_out),
    .vblnk_o  (vblnk_out)
  );

  assign rom_addr      = rom_addr_q;
  assign rom_sel       = rom_sel_q;
  assign rgb_out       = rgb_q;
  assign screen_active = screen_active_q;

endmodule
`default_nettype wire
